sistema_hex_display_ctrl: RTL

- Avalon-MM slave driving NUM_DIGITS seven-segment digits from the Nios II system bus.
- Parametrised successor to the fixed-width HEX PIO output ports.
- Adds per-digit hex decode or raw-segment mode, blank mask, and hardware blink with a programmable prescaler.
- Sits on the system interconnect; out_port goes straight to the HEX pins.

---
 rtl/sistema_hex_display_ctrl_if.sv | 24 ++
 rtl/sistema_hex_display_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sistema_hex_display_ctrl_if.sv
// Avalon-MM slave port bundle for the hex display controller.
interface sistema_hex_display_ctrl_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/sistema_hex_display_ctrl.sv
// Seven-segment display controller: per-digit hex/raw mode, blank mask,
// and prescaled hardware blink, programmed over an Avalon-MM slave port.
module sistema_hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 2,
  parameter int unsigned DIV_W      = 26,
  parameter int unsigned ACTIVE_LOW = 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  sistema_hex_display_ctrl_if.slave bus,
  output logic [7*NUM_DIGITS-1:0]   out_port
);

  localparam int unsigned VAL_W = 4 * NUM_DIGITS;
  localparam int unsigned SEG_W = 7 * NUM_DIGITS;

  localparam logic [2:0] ADDR_VALUE  = 3'd0;
  localparam logic [2:0] ADDR_MODE   = 3'd1;
  localparam logic [2:0] ADDR_RAW_LO = 3'd2;
  localparam logic [2:0] ADDR_RAW_HI = 3'd3;
  localparam logic [2:0] ADDR_BLANK  = 3'd4;
  localparam logic [2:0] ADDR_BLINK  = 3'd5;
  localparam logic [2:0] ADDR_DIV    = 3'd6;
  localparam logic [2:0] ADDR_STATUS = 3'd7;

  // Pattern XORed onto active-high segments to get pin polarity; also the dark code.
  localparam logic [6:0] SEG_DARK = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;

  logic [VAL_W-1:0]           value_q, value_d;
  logic [NUM_DIGITS-1:0]      mode_q, mode_d;
  logic [NUM_DIGITS-1:0][6:0] raw_q, raw_d;
  logic [NUM_DIGITS-1:0]      blank_q, blank_d;
  logic [NUM_DIGITS-1:0]      blink_q, blink_d;
  logic [DIV_W-1:0]           div_q, div_d;
  logic [DIV_W-1:0]           cnt_q, cnt_d;
  logic                       phase_q, phase_d;
  logic [SEG_W-1:0]           seg_q, seg_d;

  logic                       wr_en_c;
  logic [31:0]                rdata_c;
  logic [NUM_DIGITS-1:0]      lit_c;
  logic [NUM_DIGITS-1:0][6:0] pat_c;
  logic                       unused_wdata_c;

  // Active-high g..a pattern for a hex nibble.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [6:0] s;
    unique case (nib)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign wr_en_c        = bus.chipselect && !bus.write_n;
  assign unused_wdata_c = ^bus.writedata;

  // Register writes and blink prescaler next state.
  always_comb begin
    value_d = value_q;
    mode_d  = mode_q;
    raw_d   = raw_q;
    blank_d = blank_q;
    blink_d = blink_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;

    // Prescaler: a zero divider parks the phase high.
    if (div_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == '0) begin
      cnt_d   = div_q;
      phase_d = !phase_q;
    end else begin
      cnt_d   = cnt_q - DIV_W'(1);
    end

    if (wr_en_c) begin
      unique case (bus.address)
        ADDR_VALUE: value_d = bus.writedata[VAL_W-1:0];
        ADDR_MODE:  mode_d  = bus.writedata[NUM_DIGITS-1:0];
        ADDR_RAW_LO: begin
          for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (k < 4) raw_d[k] = bus.writedata[8*(k%4) +: 7];
          end
        end
        ADDR_RAW_HI: begin
          for (int k = 0; k < int'(NUM_DIGITS); k++) begin
            if (k >= 4) raw_d[k] = bus.writedata[8*(k%4) +: 7];
          end
        end
        ADDR_BLANK: blank_d = bus.writedata[NUM_DIGITS-1:0];
        ADDR_BLINK: blink_d = bus.writedata[NUM_DIGITS-1:0];
        ADDR_DIV: begin
          // Reloading the divider restarts the blink period in the lit half.
          div_d   = bus.writedata[DIV_W-1:0];
          cnt_d   = bus.writedata[DIV_W-1:0];
          phase_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-digit segment pattern from the current register state.
  always_comb begin
    lit_c = '0;
    pat_c = '0;
    seg_d = '0;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      lit_c[k] = !blank_q[k] && !(blink_q[k] && !phase_q);
      pat_c[k] = mode_q[k] ? raw_q[k] : hex_seg(value_q[4*k +: 4]);
      seg_d[7*k +: 7] = (lit_c[k] ? pat_c[k] : 7'h00) ^ SEG_DARK;
    end
  end

  // Zero-wait-state read mux; unimplemented bits read as 0.
  always_comb begin
    rdata_c = '0;
    unique case (bus.address)
      ADDR_VALUE: rdata_c = 32'(value_q);
      ADDR_MODE:  rdata_c = 32'(mode_q);
      ADDR_RAW_LO: begin
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
          if (k < 4) rdata_c[8*(k%4) +: 7] = raw_q[k];
        end
      end
      ADDR_RAW_HI: begin
        for (int k = 0; k < int'(NUM_DIGITS); k++) begin
          if (k >= 4) rdata_c[8*(k%4) +: 7] = raw_q[k];
        end
      end
      ADDR_BLANK:  rdata_c = 32'(blank_q);
      ADDR_BLINK:  rdata_c = 32'(blink_q);
      ADDR_DIV:    rdata_c = 32'(div_q);
      ADDR_STATUS: rdata_c = 32'(phase_q);
      default:     rdata_c = '0;
    endcase
  end

  assign bus.readdata = rdata_c;
  assign out_port     = seg_q;

  // State registers; reset leaves the display dark and the phase high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= '0;
      mode_q  <= '0;
      raw_q   <= '0;
      blank_q <= '0;
      blink_q <= '0;
      div_q   <= '0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      seg_q   <= {NUM_DIGITS{SEG_DARK}};
    end else begin
      value_q <= value_d;
      mode_q  <= mode_d;
      raw_q   <= raw_d;
      blank_q <= blank_d;
      blink_q <= blink_d;
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      seg_q   <= seg_d;
    end
  end

endmodule
